// File: rtl/memory_port_arbiter_if.sv
// Bundles the fetch, Memory-stage and unified-memory bus signals of memory_port_arbiter.
// master = arbiter side; slave = pipeline and memory side.
interface memory_port_arbiter_if;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchFlush;
  logic [31:0] fetchData;
  logic        fetchDataValid;

  logic        dataReadRequest;
  logic        dataWriteRequest;
  logic [31:0] dataAddress;
  logic [31:0] dataStoreData;
  logic [3:0]  dataByteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        dataError;

  logic        busRequest;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busByteEnable;
  logic [31:0] busReadData;
  logic        busReady;

  modport master (
    input  fetchRequest, fetchAddress, fetchFlush,
    output fetchData, fetchDataValid,
    input  dataReadRequest, dataWriteRequest, dataAddress, dataStoreData, dataByteEnable,
    output loadData, loadDataValid, storeComplete, dataError,
    output busRequest, busWrite, busAddress, busWriteData, busByteEnable,
    input  busReadData, busReady
  );

  modport slave (
    output fetchRequest, fetchAddress, fetchFlush,
    input  fetchData, fetchDataValid,
    output dataReadRequest, dataWriteRequest, dataAddress, dataStoreData, dataByteEnable,
    input  loadData, loadDataValid, storeComplete, dataError,
    input  busRequest, busWrite, busAddress, busWriteData, busByteEnable,
    output busReadData, busReady
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the Memory stage.
// Optional ARB_ROUND_ROBIN_EN: alternate priority on contention instead of fixed data-first.
module memory_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNTER_WIDTH  = 8
) (
  input logic                   clock,
  input logic                   reset,
  memory_port_arbiter_if.master port
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     cancel_q, cancel_d;
  logic                     bus_request_q, bus_request_d;
  logic                     bus_write_q, bus_write_d;
  logic [31:0]              bus_address_q, bus_address_d;
  logic [31:0]              bus_write_data_q, bus_write_data_d;
  logic [3:0]               bus_byte_enable_q, bus_byte_enable_d;
  logic [31:0]              fetch_data_q, fetch_data_d;
  logic                     fetch_data_valid_q, fetch_data_valid_d;
  logic [31:0]              load_data_q, load_data_d;
  logic                     load_data_valid_q, load_data_valid_d;
  logic                     store_complete_q, store_complete_d;
  logic                     data_error_q, data_error_d;

  logic data_req, fetch_ok, grant_data, grant_fetch;

  assign data_req    = port.dataReadRequest | port.dataWriteRequest;
  assign fetch_ok    = port.fetchRequest & ~port.fetchFlush;
  assign grant_fetch = fetch_ok & ~grant_data;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted last; resets to fetch-last so data wins the first contention
  logic last_grant_q, last_grant_d;

  assign grant_data = data_req & (~fetch_ok | ~last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant_data)       last_grant_d = 1'b1;
      else if (grant_fetch) last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    cancel_d           = cancel_q;
    bus_request_d      = bus_request_q;
    bus_write_d        = bus_write_q;
    bus_address_d      = bus_address_q;
    bus_write_data_d   = bus_write_data_q;
    bus_byte_enable_d  = bus_byte_enable_q;
    fetch_data_d       = fetch_data_q;
    load_data_d        = load_data_q;
    fetch_data_valid_d = 1'b0;
    load_data_valid_d  = 1'b0;
    store_complete_d   = 1'b0;
    data_error_d       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        cancel_d = 1'b0;
        if (grant_data) begin
          state_d           = DATA;
          bus_request_d     = 1'b1;
          bus_write_d       = port.dataWriteRequest;
          bus_address_d     = port.dataAddress;
          bus_write_data_d  = port.dataWriteRequest ? port.dataStoreData : 32'h0;
          bus_byte_enable_d = port.dataWriteRequest ? port.dataByteEnable : 4'b1111;
        end else if (grant_fetch) begin
          state_d           = FETCH;
          bus_request_d     = 1'b1;
          bus_write_d       = 1'b0;
          bus_address_d     = port.fetchAddress;
          bus_write_data_d  = 32'h0;
          bus_byte_enable_d = 4'b1111;
        end
      end

      // Bus cannot be aborted: a flush only marks the response as cancelled
      FETCH: begin
        if (port.fetchFlush) cancel_d = 1'b1;
        if (port.busReady) begin
          state_d            = RESP;
          bus_request_d      = 1'b0;
          fetch_data_d       = port.busReadData;
          fetch_data_valid_d = ~(cancel_q | port.fetchFlush);
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          bus_request_d = 1'b0;
          fetch_data_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end

      DATA: begin
        if (port.busReady) begin
          state_d       = RESP;
          bus_request_d = 1'b0;
          if (bus_write_q) begin
            store_complete_d = 1'b1;
          end else begin
            load_data_d       = port.busReadData;
            load_data_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          bus_request_d = 1'b0;
          data_error_d  = 1'b1;
          if (bus_write_q) begin
            store_complete_d = 1'b1;
          end else begin
            load_data_d       = 32'h0;
            load_data_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end

      // One-cycle response slot; no grant so a still-high retiring request is not re-issued
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      cancel_q           <= 1'b0;
      bus_request_q      <= 1'b0;
      bus_write_q        <= 1'b0;
      bus_address_q      <= 32'h0;
      bus_write_data_q   <= 32'h0;
      bus_byte_enable_q  <= 4'h0;
      fetch_data_q       <= 32'h0;
      fetch_data_valid_q <= 1'b0;
      load_data_q        <= 32'h0;
      load_data_valid_q  <= 1'b0;
      store_complete_q   <= 1'b0;
      data_error_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      cancel_q           <= cancel_d;
      bus_request_q      <= bus_request_d;
      bus_write_q        <= bus_write_d;
      bus_address_q      <= bus_address_d;
      bus_write_data_q   <= bus_write_data_d;
      bus_byte_enable_q  <= bus_byte_enable_d;
      fetch_data_q       <= fetch_data_d;
      fetch_data_valid_q <= fetch_data_valid_d;
      load_data_q        <= load_data_d;
      load_data_valid_q  <= load_data_valid_d;
      store_complete_q   <= store_complete_d;
      data_error_q       <= data_error_d;
    end
  end

  assign port.busRequest     = bus_request_q;
  assign port.busWrite       = bus_write_q;
  assign port.busAddress     = bus_address_q;
  assign port.busWriteData   = bus_write_data_q;
  assign port.busByteEnable  = bus_byte_enable_q;
  assign port.fetchData      = fetch_data_q;
  assign port.fetchDataValid = fetch_data_valid_q;
  assign port.loadData       = load_data_q;
  assign port.loadDataValid  = load_data_valid_q;
  assign port.storeComplete  = store_complete_q;
  assign port.dataError      = data_error_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter (TIMEOUT_CYCLES = 4); inputs change and outputs are sampled on the falling edge.
module tb_memory_port_arbiter;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  memory_port_arbiter_if bus_if ();

  memory_port_arbiter #(
    .TIMEOUT_CYCLES(4),
    .COUNTER_WIDTH (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .port (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Both requesters raise in the same cycle; busReady held high so each grant completes at once
  task automatic contend(input bit data_first, input logic [31:0] faddr, input logic [31:0] daddr,
                         input logic [31:0] rd1, input logic [31:0] rd2);
    bus_if.fetchRequest    = 1'b1;
    bus_if.fetchAddress    = faddr;
    bus_if.dataReadRequest = 1'b1;
    bus_if.dataAddress     = daddr;
    bus_if.busReady        = 1'b1;
    bus_if.busReadData     = rd1;
    step();
    check("cont_req1", 32'(bus_if.busRequest), 32'd1);
    check("cont_addr1", bus_if.busAddress, data_first ? daddr : faddr);
    step();
    if (data_first) begin
      check("cont_load1_v", 32'(bus_if.loadDataValid), 32'd1);
      check("cont_load1_d", bus_if.loadData, rd1);
      bus_if.dataReadRequest = 1'b0;
    end else begin
      check("cont_fetch1_v", 32'(bus_if.fetchDataValid), 32'd1);
      check("cont_fetch1_d", bus_if.fetchData, rd1);
      bus_if.fetchRequest = 1'b0;
    end
    bus_if.busReadData = rd2;
    step();
    check("cont_resp_gap", 32'(bus_if.busRequest), 32'd0);
    step();
    check("cont_req2", 32'(bus_if.busRequest), 32'd1);
    check("cont_addr2", bus_if.busAddress, data_first ? faddr : daddr);
    step();
    if (data_first) begin
      check("cont_fetch2_v", 32'(bus_if.fetchDataValid), 32'd1);
      check("cont_fetch2_d", bus_if.fetchData, rd2);
      bus_if.fetchRequest = 1'b0;
    end else begin
      check("cont_load2_v", 32'(bus_if.loadDataValid), 32'd1);
      check("cont_load2_d", bus_if.loadData, rd2);
      bus_if.dataReadRequest = 1'b0;
    end
    bus_if.busReady = 1'b0;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus_if.fetchRequest     = 1'b0;
    bus_if.fetchAddress     = 32'h0;
    bus_if.fetchFlush       = 1'b0;
    bus_if.dataReadRequest  = 1'b0;
    bus_if.dataWriteRequest = 1'b0;
    bus_if.dataAddress      = 32'h0;
    bus_if.dataStoreData    = 32'h0;
    bus_if.dataByteEnable   = 4'h0;
    bus_if.busReadData      = 32'h0;
    bus_if.busReady         = 1'b0;

    // Reset state
    step();
    step();
    check("rst_busreq", 32'(bus_if.busRequest), 32'd0);
    check("rst_busaddr", bus_if.busAddress, 32'h0);
    check("rst_pulses", {29'd0, bus_if.fetchDataValid, bus_if.loadDataValid, bus_if.storeComplete}, 32'd0);
    reset = 1'b1;
    step();

    // Fetch only, zero wait states
    bus_if.fetchRequest = 1'b1;
    bus_if.fetchAddress = 32'h100;
    step();
    check("fetch_busreq", 32'(bus_if.busRequest), 32'd1);
    check("fetch_buswr", 32'(bus_if.busWrite), 32'd0);
    check("fetch_busaddr", bus_if.busAddress, 32'h100);
    check("fetch_be", 32'(bus_if.busByteEnable), 32'hF);
    bus_if.busReady    = 1'b1;
    bus_if.busReadData = 32'h0000_0013;
    step();
    check("fetch_valid", 32'(bus_if.fetchDataValid), 32'd1);
    check("fetch_data", bus_if.fetchData, 32'h0000_0013);
    check("fetch_busreq_drop", 32'(bus_if.busRequest), 32'd0);
    bus_if.fetchRequest = 1'b0;
    bus_if.busReady     = 1'b0;
    step();
    check("fetch_valid_once", 32'(bus_if.fetchDataValid), 32'd0);

    // First contention: data wins in either priority scheme
    contend(1'b1, 32'h300, 32'h400, 32'hDEAD_0001, 32'h1357_9BDF);

    // Store with three wait states; request stays high through the response slot
    bus_if.dataWriteRequest = 1'b1;
    bus_if.dataAddress      = 32'h2002;
    bus_if.dataByteEnable   = 4'b1100;
    bus_if.dataStoreData    = 32'hABCD_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_busreq", 32'(bus_if.busRequest), 32'd1);
      check("st_fields", {bus_if.busAddress[15:0], 11'd0, bus_if.busWrite, bus_if.busByteEnable},
            {16'h2002, 11'd0, 1'b1, 4'b1100});
      check("st_wdata", bus_if.busWriteData, 32'hABCD_0000);
      check("st_no_early", 32'(bus_if.storeComplete), 32'd0);
    end
    bus_if.busReady = 1'b1;
    step();
    check("st_complete", 32'(bus_if.storeComplete), 32'd1);
    check("st_err", 32'(bus_if.dataError), 32'd0);
    check("st_busreq_drop", 32'(bus_if.busRequest), 32'd0);
    bus_if.busReady = 1'b0;
    step();
    check("st_no_regrant", 32'(bus_if.busRequest), 32'd0);
    check("st_single", 32'(bus_if.storeComplete), 32'd0);
    bus_if.dataWriteRequest = 1'b0;
    step();
    check("st_idle", 32'(bus_if.busRequest), 32'd0);

    // Second contention: data was granted last, so round-robin serves fetch first
`ifdef ARB_ROUND_ROBIN_EN
    contend(1'b0, 32'h310, 32'h410, 32'h2222_0000, 32'h3333_0000);
`else
    contend(1'b1, 32'h310, 32'h410, 32'h2222_0000, 32'h3333_0000);
`endif

    // Flush of an in-flight fetch
    bus_if.fetchRequest = 1'b1;
    bus_if.fetchAddress = 32'h500;
    bus_if.busReadData  = 32'hFFFF_0000;
    step();
    check("fl_busreq1", 32'(bus_if.busRequest), 32'd1);
    step();
    bus_if.fetchFlush   = 1'b1;
    bus_if.fetchRequest = 1'b0;
    step();
    check("fl_busreq3", 32'(bus_if.busRequest), 32'd1);
    bus_if.fetchFlush = 1'b0;
    step();
    bus_if.busReady = 1'b1;
    step();
    check("fl_no_valid", 32'(bus_if.fetchDataValid), 32'd0);
    check("fl_busreq_drop", 32'(bus_if.busRequest), 32'd0);
    bus_if.busReady = 1'b0;
    step();
    check("fl_no_valid2", 32'(bus_if.fetchDataValid), 32'd0);
    // Flush in IDLE blocks the grant, then the fetch is served once flush drops
    bus_if.fetchRequest = 1'b1;
    bus_if.fetchAddress = 32'h600;
    bus_if.fetchFlush   = 1'b1;
    step();
    check("fl_idle_block", 32'(bus_if.busRequest), 32'd0);
    bus_if.fetchFlush = 1'b0;
    step();
    check("fl_refetch_req", 32'(bus_if.busRequest), 32'd1);
    check("fl_refetch_addr", bus_if.busAddress, 32'h600);
    bus_if.busReady    = 1'b1;
    bus_if.busReadData = 32'h0000_0077;
    step();
    check("fl_refetch_valid", 32'(bus_if.fetchDataValid), 32'd1);
    check("fl_refetch_data", bus_if.fetchData, 32'h0000_0077);
    bus_if.fetchRequest = 1'b0;
    bus_if.busReady     = 1'b0;
    step();

    // Load timeout after four cycles of busRequest
    bus_if.dataReadRequest = 1'b1;
    bus_if.dataAddress     = 32'h800;
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_busreq", 32'(bus_if.busRequest), 32'd1);
    end
    step();
    check("to_busreq_drop", 32'(bus_if.busRequest), 32'd0);
    check("to_valid", 32'(bus_if.loadDataValid), 32'd1);
    check("to_err", 32'(bus_if.dataError), 32'd1);
    check("to_data", bus_if.loadData, 32'h0);
    bus_if.dataReadRequest = 1'b0;
    step();
    check("to_err_clear", 32'(bus_if.dataError), 32'd0);

    // Asynchronous reset in the middle of a data transaction
    bus_if.dataReadRequest = 1'b1;
    bus_if.dataAddress     = 32'h900;
    step();
    check("ar_busreq", 32'(bus_if.busRequest), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_busreq_async", 32'(bus_if.busRequest), 32'd0);
    check("ar_pulses", {29'd0, bus_if.fetchDataValid, bus_if.loadDataValid, bus_if.storeComplete}, 32'd0);
    bus_if.dataReadRequest = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("ar_idle", 32'(bus_if.busRequest), 32'd0);
    bus_if.dataReadRequest = 1'b1;
    bus_if.dataAddress     = 32'hA00;
    bus_if.busReady        = 1'b1;
    bus_if.busReadData     = 32'h0000_4242;
    step();
    check("ar_fresh_req", 32'(bus_if.busRequest), 32'd1);
    check("ar_fresh_addr", bus_if.busAddress, 32'hA00);
    step();
    check("ar_fresh_valid", 32'(bus_if.loadDataValid), 32'd1);
    check("ar_fresh_data", bus_if.loadData, 32'h0000_4242);
    bus_if.dataReadRequest = 1'b0;
    bus_if.busReady        = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (read-only) and the Memory stage (loads/stores).
- Accepts level-held requests from both sides and grants one transaction at a time.
- Drives the bus until busReady and returns a one-cycle response pulse to the winning requester.
- Sits between the pipeline front/Memory stages and the unified memory; supplies loadData/loadDataValid/storeComplete consumed by the Memory stage.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for busReady before aborting with error (1..255)
- COUNTER_WIDTH, 8, width of the timeout counter

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fetchRequest  input  1  fetch read request, held until fetchDataValid or fetchFlush
- fetchAddress  input  32  word-aligned fetch address
- fetchFlush  input  1  cancel pending/in-flight fetch response
- fetchData  output  32  fetch read data
- fetchDataValid  output  1  one-cycle response pulse for fetch
- dataReadRequest  input  1  load request, held until loadDataValid
- dataWriteRequest  input  1  store request (storeValid), held until storeComplete
- dataAddress  input  32  load/store address
- dataStoreData  input  32  pre-shifted store data
- dataByteEnable  input  4  pre-shifted store byte enables
- loadData  output  32  raw load word
- loadDataValid  output  1  one-cycle load response pulse
- storeComplete  output  1  one-cycle store response pulse
- dataError  output  1  qualifies loadDataValid/storeComplete: transaction timed out
- busRequest  output  1  bus transaction active
- busWrite  output  1  1 = write
- busAddress  output  32  bus address
- busWriteData  output  32  bus write data
- busByteEnable  output  4  write byte enables; 4'b1111 on reads
- busReadData  input  32  read data, valid when busReady
- busReady  input  1  completes the current transaction this cycle

Behaviour:
- All outputs registered.
- Reset (reset=0, asynchronous) forces state IDLE, counter 0, and every output 0.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - If dataReadRequest|dataWriteRequest: latch data address/data/enables, drive bus, go to DATA.
  - Else if fetchRequest && !fetchFlush: latch fetchAddress, drive bus read, go to FETCH.
  - Data wins by default.
  - busRequest rises the cycle after the request is first seen.
- FETCH/DATA:
  - Bus outputs are held stable while busRequest=1.
  - The cycle busReady=1 completes the transfer: capture busReadData, go to RESP, drop busRequest.
- RESP:
  - Exactly one cycle.
  - Pulses fetchDataValid, loadDataValid or storeComplete, with data on fetchData/loadData.
  - No new grant is issued in RESP; this prevents re-issuing a still-high request from the instruction being retired.
  - Next state is IDLE.
- Request precedence: dataWriteRequest and dataReadRequest both high is illegal; write takes precedence.
- fetchFlush:
  - Asserted any cycle while FETCH is active: the bus transaction still completes (the bus cannot be aborted).
  - A sticky cancel bit suppresses fetchDataValid in RESP.
  - Flush in IDLE blocks a fetch grant that cycle.
- Stores are never cancelled.
- Timeout:
  - The counter increments each FETCH/DATA cycle with busReady=0.
  - On reaching TIMEOUT_CYCLES: drop busRequest, go to RESP, return a pulse with data 0.
  - dataError=1 for data transactions; a fetch timeout is silently dropped (no pulse).
  - The counter clears on entry to IDLE.
- busReady in IDLE/RESP is ignored.
- Reset mid-transaction: immediate return to IDLE, busRequest=0, no response pulse.
- Minimum latency: request at cycle N, busRequest at N+1, busReady at N+1 → response pulse at N+2.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A one-bit lastGrant register sets priority.
  - When both requesters are pending in IDLE, the one not granted last wins; the register updates on each grant.
  - The register resets to "fetch last", so data wins the first contention.
- Undefined: fixed data-over-fetch priority; fetch can starve under back-to-back data traffic.

Test Plan:
- Fetch only: fetchRequest=1, fetchAddress=0x100, busReady at first busRequest cycle, busReadData=0x00000013 → busRequest=1 with busWrite=0, busAddress=0x100, busByteEnable=4'b1111; fetchDataValid pulse with fetchData=0x00000013 one cycle later.
- Store: dataWriteRequest=1, dataAddress=0x2002, dataByteEnable=4'b1100, dataStoreData=0xABCD0000, busReady after 3 wait cycles → bus fields held stable for 4 cycles; single storeComplete pulse; no second bus transaction while the request is still high in RESP.
- Contention: both requests high in the same cycle → data granted first; fetch granted in the IDLE after RESP. With ARB_ROUND_ROBIN_EN, a second contention grants fetch first.
- Flush: fetch in flight, fetchFlush pulse at wait cycle 2, busReady at cycle 4 → transaction completes, no fetchDataValid, arbiter back in IDLE.
- Timeout: TIMEOUT_CYCLES=4, load with busReady=0 → busRequest drops after 4 cycles; loadDataValid=1, dataError=1, loadData=0.
- Async reset asserted mid-DATA → busRequest and all pulses 0 immediately, without waiting for a clock edge; after release, a fresh request is served normally.
